// File: rtl/sata_trace_capture_if.sv
// sata_trace_capture_if: probe capture controls and pipelined register-read port of the trace buffer
interface sata_trace_capture_if #(parameter int C_ADDR_W = 9);
  logic [127:0]        TRIG0;
  logic                TRIG_IN;
  logic                ARM;
  logic                STOP;
  logic                TRIG_OUT;
  logic                BUSY;
  logic                DONE;
  logic                WRAPPED;
  logic [C_ADDR_W-1:0] TRIG_PTR;
  logic [C_ADDR_W-1:0] WR_PTR;
  logic                RD_REQ;
  logic [C_ADDR_W-1:0] RD_ADDR;
  logic [1:0]          RD_SEL;
  logic                RD_ACK;
  logic [31:0]         RD_DATA;
  logic                RD_ERR;
  modport slave (
    input  TRIG0, TRIG_IN, ARM, STOP, RD_REQ, RD_ADDR, RD_SEL,
    output TRIG_OUT, BUSY, DONE, WRAPPED, TRIG_PTR, WR_PTR, RD_ACK, RD_DATA, RD_ERR
  );
  modport master (
    output TRIG0, TRIG_IN, ARM, STOP, RD_REQ, RD_ADDR, RD_SEL,
    input  TRIG_OUT, BUSY, DONE, WRAPPED, TRIG_PTR, WR_PTR, RD_ACK, RD_DATA, RD_ERR
  );
endinterface

// File: rtl/sata_trace_capture.sv
// sata_trace_capture: circular 128-bit probe trace buffer around a trigger, read back 32 bits at a time
module sata_trace_capture #(
  parameter int C_DEPTH  = 512,
  parameter int C_ADDR_W = 9,
  parameter int C_POST   = 256
) (
  input logic CLK,
  input logic RST_N,
  sata_trace_capture_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;
  state_t st, ns;
  logic [127:0] mem [C_DEPTH];
  logic [127:0] ram_q;
  logic [C_ADDR_W-1:0] wr_ptr, trig_ptr, post_cnt;
  logic trig_out, busy, done, wrapped, we, trig_hit;
  logic req1, err1;
  logic [1:0] sel1;
  logic rd_ack, rd_err;
  logic [31:0] rd_data;
  assign we = (st == S_ARMED || st == S_POST) && !bus.ARM;
  always_comb begin
    ns = st;
    trig_hit = 1'b0;
    if (bus.ARM) ns = S_ARMED;
    else if (st == S_ARMED) begin
      trig_hit = !bus.STOP && bus.TRIG_IN;
      ns = bus.STOP ? S_DONE : bus.TRIG_IN ? (C_POST == 0 ? S_DONE : S_POST) : S_ARMED;
    end else if (st == S_POST && (bus.STOP || post_cnt == C_ADDR_W'(C_POST - 1))) ns = S_DONE;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st       <= S_IDLE;
      wr_ptr   <= '0;
      trig_ptr <= '0;
      post_cnt <= '0;
      trig_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      st       <= ns;
      trig_out <= trig_hit;
      busy     <= ns == S_ARMED || ns == S_POST;
      done     <= ns == S_DONE;
      if (bus.ARM) begin
        wr_ptr   <= '0;
        trig_ptr <= '0;
        post_cnt <= '0;
        wrapped  <= 1'b0;
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (&wr_ptr) wrapped <= 1'b1;
        if (st == S_POST) post_cnt <= post_cnt + 1'b1;
        if (trig_hit) trig_ptr <= wr_ptr;
      end
    end
  end
  // RAM has no reset so it maps onto block RAM; the registered read is the first latency stage
  always_ff @(posedge CLK) begin
    if (we) mem[wr_ptr] <= bus.TRIG0;
    ram_q <= mem[bus.RD_ADDR];
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req1    <= 1'b0;
      err1    <= 1'b0;
      sel1    <= '0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
      rd_data <= '0;
    end else begin
      req1    <= bus.RD_REQ;
      err1    <= busy;
      sel1    <= bus.RD_SEL;
      rd_ack  <= req1;
      rd_err  <= req1 && err1;
      rd_data <= (req1 && !err1) ? ram_q[{sel1, 5'd0} +: 32] : 32'h0;
    end
  end
  assign bus.TRIG_OUT = trig_out;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.WRAPPED  = wrapped;
  assign bus.TRIG_PTR = trig_ptr;
  assign bus.WR_PTR   = wr_ptr;
  assign bus.RD_ACK   = rd_ack;
  assign bus.RD_DATA  = rd_data;
  assign bus.RD_ERR   = rd_err;
endmodule

// File: tb/tb_sata_trace_capture.sv
// tb_sata_trace_capture: scenario tasks for capture control plus a queue scoreboard on the read port
module tb_sata_trace_capture;
  localparam int D = 16, AW = 4, P = 4;
  logic CLK = 1'b0, RST_N = 1'b0;
  always #5 CLK = ~CLK;
  sata_trace_capture_if #(.C_ADDR_W(AW)) bus();
  sata_trace_capture #(.C_DEPTH(D), .C_ADDR_W(AW), .C_POST(P)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  typedef struct {int cyc; logic err; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int rq_addr[$], rq_sel[$];
  int checks = 0, failures = 0, cyc = 0;
  bit trig_seen = 0;
  logic [127:0] model [D];

  function automatic logic [127:0] pat(input int i);
    return {8'hD3, 24'(i), 8'hC2, 24'(i), 8'hB1, 24'(i), 8'hA0, 24'(i)};
  endfunction

  function automatic logic [11:0] status();
    return {bus.TRIG_OUT, bus.BUSY, bus.DONE, bus.WRAPPED, bus.TRIG_PTR, bus.WR_PTR};
  endfunction

  task automatic step(input logic [127:0] d, input logic trig, input logic stop, input logic arm);
    bus.TRIG0 = d; bus.TRIG_IN = trig; bus.STOP = stop; bus.ARM = arm;
    @(posedge CLK); #1; cyc++;
    bus.TRIG_IN = 1'b0; bus.STOP = 1'b0; bus.ARM = 1'b0;
    if (bus.TRIG_OUT) trig_seen = 1;
  endtask

  task automatic do_reads(input logic exp_err);
    int n;
    logic [127:0] w;
    exp_t e;
    n = rq_addr.size();
    for (int t = 0; t < n + 6; t++) begin
      if (t < n) begin
        bus.RD_REQ = 1'b1; bus.RD_ADDR = AW'(rq_addr[t]); bus.RD_SEL = 2'(rq_sel[t]);
        w = model[rq_addr[t]];
        sb.push_back('{cyc, exp_err, exp_err ? 32'h0 : w[rq_sel[t]*32 +: 32]});
      end else bus.RD_REQ = 1'b0;
      step(bus.TRIG0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.RD_ACK) begin
        if (sb.size() == 0) begin
          failures++; $display("FAIL rd_spurious_ack data=%h err=%b required no ack", bus.RD_DATA, bus.RD_ERR);
        end else begin
          e = sb.pop_front();
          if ({bus.RD_ERR, bus.RD_DATA, cyc} !== {e.err, e.data, e.cyc + 2}) begin
            failures++;
            $display("FAIL rd_resp got err=%b data=%h cyc=%0d required err=%b data=%h cyc=%0d",
                     bus.RD_ERR, bus.RD_DATA, cyc, e.err, e.data, e.cyc + 2);
          end
        end
      end else if ({bus.RD_ERR, bus.RD_DATA} !== 33'h0) begin
        failures++; $display("FAIL rd_idle got err=%b data=%h required 0", bus.RD_ERR, bus.RD_DATA);
      end
      if (t >= n && sb.size() == 0) break;
    end
    bus.RD_REQ = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL rd_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    rq_addr.delete(); rq_sel.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({status(), bus.RD_ACK, bus.RD_ERR, bus.RD_DATA} !== 46'h0) begin
      failures++; $display("FAIL reset_state got=%b/%b/%b/%h required all 0", status(), bus.RD_ACK, bus.RD_ERR, bus.RD_DATA);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_early_trigger();
    step('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      failures++; $display("FAIL et_armed got=%b required=%b", status(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
    end
    for (int i = 0; i < 5; i++) begin step(pat(i), 1'b0, 1'b0, 1'b0); model[i] = pat(i); end
    step(pat(5), 1'b1, 1'b0, 1'b0); model[5] = pat(5);
    checks++;
    if (status() !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd6}) begin
      failures++; $display("FAIL et_trigger got=%b required=%b", status(), {1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd6});
    end
    for (int i = 6; i < 9; i++) begin step(pat(i), 1'b1, 1'b0, 1'b0); model[i] = pat(i); end
    checks++;
    if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd9}) begin
      failures++; $display("FAIL et_post got=%b required=%b", status(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd9});
    end
    step(pat(9), 1'b0, 1'b0, 1'b0); model[9] = pat(9);
    checks++;
    if (status() !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd10}) begin
      failures++; $display("FAIL et_done got=%b required=%b", status(), {1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd10});
    end
    for (int i = 0; i < 10; i++) begin rq_addr.push_back(i); rq_sel.push_back(i % 4); end
    do_reads(1'b0);
  endtask

  task automatic test_wrap();
    step('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 45; i++) begin
      step(pat(100 + i), i == 40, 1'b0, 1'b0);
      model[i % D] = pat(100 + i);
    end
    checks++;
    if (status() !== {1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd13}) begin
      failures++; $display("FAIL wrap_done got=%b required=%b", status(), {1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd13});
    end
    for (int i = 0; i < D; i++) begin rq_addr.push_back((13 + i) % D); rq_sel.push_back(i % 4); end
    do_reads(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) begin rq_addr.push_back(5); rq_sel.push_back(s); end
    do_reads(1'b0);
  endtask

  task automatic test_read_busy();
    step('0, 1'b0, 1'b0, 1'b1);
    for (int a = 1; a < 4; a++) begin rq_addr.push_back(a); rq_sel.push_back(a); end
    do_reads(1'b1);
    step('0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.DONE !== 1'b1) begin
      failures++; $display("FAIL busy_stop got=%b required=1", bus.DONE);
    end
  endtask

  task automatic test_early_stop();
    step('0, 1'b0, 1'b0, 1'b1);
    trig_seen = 0;
    step(pat(0), 1'b0, 1'b0, 1'b0);
    step(pat(1), 1'b0, 1'b0, 1'b0);
    step(pat(2), 1'b0, 1'b1, 1'b0);
    checks++;
    if (status() !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3}) begin
      failures++; $display("FAIL stop_done got=%b required=%b", status(), {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3});
    end
    step(pat(3), 1'b1, 1'b0, 1'b0);
    checks++;
    if ({trig_seen, status()} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3}) begin
      failures++; $display("FAIL stop_no_trig got seen=%b status=%b required seen=0 status unchanged", trig_seen, status());
    end
    step('0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      failures++; $display("FAIL arm_beats_stop got=%b required=%b", status(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
    end
  endtask

  task automatic test_reset_post();
    step(pat(0), 1'b1, 1'b0, 1'b0);
    checks++;
    if (status() !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1}) begin
      failures++; $display("FAIL rp_post got=%b required=%b", status(), {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1});
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({status(), bus.RD_ACK, bus.RD_ERR, bus.RD_DATA} !== 46'h0) begin
      failures++; $display("FAIL rp_async_reset got=%b/%b/%b/%h required all 0", status(), bus.RD_ACK, bus.RD_ERR, bus.RD_DATA);
    end
    #1 RST_N = 1'b1;
    step('0, 1'b0, 1'b0, 1'b1);
    step(pat(50), 1'b1, 1'b0, 1'b0);
    checks++;
    if (status() !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1}) begin
      failures++; $display("FAIL rp_first_cycle_trig got=%b required=%b", status(), {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1});
    end
    for (int i = 1; i <= P; i++) step(pat(50 + i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (status() !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5}) begin
      failures++; $display("FAIL rp_capture_done got=%b required=%b", status(), {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5});
    end
  endtask

  initial begin
    bus.TRIG0 = '0; bus.TRIG_IN = 1'b0; bus.ARM = 1'b0; bus.STOP = 1'b0;
    bus.RD_REQ = 1'b0; bus.RD_ADDR = '0; bus.RD_SEL = '0;
    test_reset();
    test_early_trigger();
    test_wrap();
    test_back_to_back();
    test_read_busy();
    test_early_stop();
    test_reset_post();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sata_trace_capture.md
Name: sata_trace_capture

Overview:
- In-fabric trace buffer for SATA link/transport debug.
- Samples the same 128-bit probe vector the team feeds to ChipScope ILA cores and stores it in a circular RAM around a trigger event.
- After capture, the stored words are read back 32 bits at a time over a simple pipelined register-read port, so a host or a DCR/PLB slave can dump traces without JTAG.
- The block is the reader end of the probe path: ILA-compatible on the capture side, bus-readable on the other.

Parameters:
- C_DEPTH, 512, number of 128-bit sample words; must be a power of two, at least 4.
- C_ADDR_W, 9, log2(C_DEPTH).
- C_POST, 256, samples captured after the trigger sample; legal range 0..C_DEPTH-1.

Ports:
- CLK  in  1  single clock for capture and readout.
- RST_N  in  1  asynchronous, active-low reset.
- TRIG0  in  128  probe vector, sampled every CLK while capturing.
- TRIG_IN  in  1  trigger condition, level-sampled.
- ARM  in  1  one-cycle pulse; starts a new capture.
- STOP  in  1  one-cycle pulse; forces the capture to finish early.
- TRIG_OUT  out  1  registered one-cycle pulse when the trigger is accepted.
- BUSY  out  1  high in ARMED or POST.
- DONE  out  1  high in DONE.
- WRAPPED  out  1  write pointer has wrapped at least once since ARM, so all C_DEPTH words are valid.
- TRIG_PTR  out  C_ADDR_W  physical address of the trigger sample.
- WR_PTR  out  C_ADDR_W  next physical write address.
- RD_REQ  in  1  read request, one per cycle allowed.
- RD_ADDR  in  C_ADDR_W  physical word address.
- RD_SEL  in  2  32-bit lane select; 0 selects bits [31:0], 3 selects bits [127:96].
- RD_ACK  out  1  read response valid.
- RD_DATA  out  32  read data.
- RD_ERR  out  1  read was issued while BUSY.

Behaviour:
- Reset, asynchronous on RST_N low:
  - State goes to IDLE.
  - TRIG_OUT, BUSY, DONE, WRAPPED, TRIG_PTR, WR_PTR, RD_ACK, RD_DATA and RD_ERR all go to 0.
  - RAM contents are not cleared.
  - Reset mid-capture abandons the capture; after reset, DONE=0.
- States are IDLE, ARMED, POST, DONE.
- IDLE: no RAM writes. ARM moves the state to ARMED and clears WR_PTR, WRAPPED and the post counter.
- ARMED:
  - Each cycle, TRIG0 is written at WR_PTR and WR_PTR increments modulo C_DEPTH.
  - WRAPPED sets when WR_PTR steps from C_DEPTH-1 to 0.
  - If TRIG_IN=1, the sample written in that cycle is the trigger sample: TRIG_PTR takes that address and TRIG_OUT pulses on the next cycle.
  - On trigger, if C_POST=0 the state goes to DONE; otherwise it goes to POST.
  - A trigger on the first armed cycle is legal.
- POST:
  - Writing continues and TRIG_IN is ignored.
  - After exactly C_POST further samples the state goes to DONE.
  - The last written address is (TRIG_PTR + C_POST) mod C_DEPTH.
- DONE: writes stop; WR_PTR holds the next address after the last sample.
- STOP in ARMED or POST moves the state to DONE at once; the sample written in that cycle is kept. If STOP arrives in ARMED, TRIG_PTR stays 0 and TRIG_OUT does not pulse.
- ARM in any state, including during a capture, restarts from a clean ARMED state. If ARM and STOP arrive in the same cycle, ARM wins.
- Oldest valid sample is at WR_PTR when WRAPPED=1, otherwise at address 0.
- Read port:
  - Fully pipelined, fixed 2-cycle latency: RD_REQ in cycle N gives RD_ACK=1 in cycle N+2. The latency is one registered RAM read plus a registered lane mux.
  - Back-to-back requests return back-to-back responses in order.
  - If the request was issued while BUSY: RD_ERR=1 and RD_DATA=0 with that RD_ACK.
  - If the request was issued in IDLE or DONE: RD_ERR=0 and RD_DATA holds the selected lane.
  - When RD_ACK=0, RD_DATA=0 and RD_ERR=0.
- All outputs are registered.

Test Plan:
- Use C_DEPTH=16, C_POST=4.
- Early trigger: TRIG0 = cycle index. ARM, then TRIG_IN on the 6th armed cycle -> TRIG_PTR=5, TRIG_OUT pulses 1 cycle later, DONE after 4 more samples, WR_PTR=10, WRAPPED=0, RAM words 0..9 = 0..9.
- Wrap: ARM, run 40 cycles, then trigger -> WRAPPED=1, TRIG_PTR=40 mod 16=8, the last 16 samples are intact, and the oldest sample is at WR_PTR=13.
- Readback: in DONE, RD_REQ for address 5 with RD_SEL 0..3 on consecutive cycles -> four RD_ACKs starting 2 cycles later, lanes in order, RD_ERR=0.
- Read while busy: RD_REQ during ARMED -> RD_ACK after 2 cycles with RD_ERR=1 and RD_DATA=0.
- Early stop: STOP in ARMED on cycle 3 -> DONE next cycle, TRIG_OUT never pulses, TRIG_PTR=0, WR_PTR=3. Then ARM and STOP together -> state ARMED.
- Reset during POST -> all outputs 0 immediately. A following ARM runs a normal capture.
